instr_fetch_unit: RTL and testbench

Byte-serial instruction fetch stage that sits directly upstream of the single-cycle processor core. It reads the byte-wide, big-endian instruction memory one byte per cycle and assembles 32-bit instruction words. Each word goes into a small FIFO together with its PC. The core pops words with a valid/ready handshake and redirects the fetch stream on any taken branch or jump.

---
 rtl/instr_fetch_unit_if.sv | 45 ++++
 rtl/instr_fetch_unit.sv | 122 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: redirect input, byte-wide instruction memory port,
// and the valid/ready instruction queue towards the core.
//   master : the fetch unit (drives imem_addr and the inst_* outputs)
//   slave  : the core plus instruction memory (drives everything else)
interface instr_fetch_unit_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 4
) ();
    logic                      redirect;
    logic [31:0]               redirect_pc;
    logic [ADDR_W-1:0]         imem_addr;
    logic [7:0]                imem_rdata;
    logic                      inst_valid;
    logic [31:0]               inst;
    logic [31:0]               inst_pc;
    logic                      inst_ready;
    logic [$clog2(DEPTH):0]    fifo_count;
    logic                      fetch_stall;

    modport master (
        input  redirect,
        input  redirect_pc,
        input  imem_rdata,
        input  inst_ready,
        output imem_addr,
        output inst_valid,
        output inst,
        output inst_pc,
        output fifo_count,
        output fetch_stall
    );

    modport slave (
        output redirect,
        output redirect_pc,
        output imem_rdata,
        output inst_ready,
        input  imem_addr,
        input  inst_valid,
        input  inst,
        input  inst_pc,
        input  fifo_count,
        input  fetch_stall
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Byte-serial instruction fetch: assembles big-endian 32-bit words from a
// byte-wide memory and queues {word, pc} in a DEPTH-entry FIFO.
// Ports: clk, rst_n (sync, active-low), bus (instr_fetch_unit_if.master).
module instr_fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned ADDR_W   = 5,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_unit_if.master bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic {
        S_FETCH,
        S_HOLD
    } state_t;

    state_t          r_state;
    logic [31:0]     r_fetch_pc;
    logic [1:0]      r_cnt;
    logic [31:0]     r_asm;
    logic [31:0]     r_word [DEPTH];
    logic [31:0]     r_pc   [DEPTH];
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;

    logic            w_valid;
    logic            w_pop;
    logic            w_push_ok;
    logic            w_push;
    logic [31:0]     w_done_word;
    logic [31:0]     w_push_word;
    logic [31:0]     w_addr_sum;

    assign w_valid   = (r_count != '0);
    assign w_pop     = w_valid & bus.inst_ready;
    // A pop on the same edge frees the slot the push needs.
    assign w_push_ok = (r_count < CW'(DEPTH)) | w_pop;

    assign w_done_word = {r_asm[31:8], bus.imem_rdata};
    assign w_push_word = (r_state == S_HOLD) ? r_asm : w_done_word;

    always_comb begin
        w_push = 1'b0;
        case (r_state)
            S_FETCH: w_push = (r_cnt == 2'd3) & w_push_ok;
            S_HOLD:  w_push = w_push_ok;
            default: w_push = 1'b0;
        endcase
    end

    // In HOLD cnt stays at 3, so the address parks on the last byte.
    assign w_addr_sum    = r_fetch_pc + {30'b0, r_cnt};
    assign bus.imem_addr = w_addr_sum[ADDR_W-1:0];

    assign bus.inst_valid  = w_valid;
    assign bus.inst        = r_word[r_rd_ptr];
    assign bus.inst_pc     = r_pc[r_rd_ptr];
    assign bus.fifo_count  = r_count;
    assign bus.fetch_stall = (r_state == S_HOLD);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_FETCH;
            r_fetch_pc <= RESET_PC;
            r_cnt      <= 2'd0;
            r_asm      <= 32'h0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_word[i] <= 32'h0;
                r_pc[i]   <= 32'h0;
            end
        end else if (bus.redirect) begin
            r_state    <= S_FETCH;
            r_fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
            r_cnt      <= 2'd0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            if (r_state == S_FETCH) begin
                unique case (r_cnt)
                    2'd0: r_asm[31:24] <= bus.imem_rdata;
                    2'd1: r_asm[23:16] <= bus.imem_rdata;
                    2'd2: r_asm[15:8]  <= bus.imem_rdata;
                    2'd3: r_asm[7:0]   <= bus.imem_rdata;
                endcase
                if (r_cnt != 2'd3) begin
                    r_cnt <= r_cnt + 2'd1;
                end else if (!w_push_ok) begin
                    r_state <= S_HOLD;
                end
            end

            // Overrides the cnt/state updates above when a word leaves.
            if (w_push) begin
                r_word[r_wr_ptr] <= w_push_word;
                r_pc[r_wr_ptr]   <= r_fetch_pc;
                r_wr_ptr         <= r_wr_ptr + 1'b1;
                r_fetch_pc       <= r_fetch_pc + 32'd4;
                r_cnt            <= 2'd0;
                r_state          <= S_FETCH;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus
// randomized ready/redirect/reset against a queue-based reference model.
module tb_instr_fetch_unit;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] mem [32];

    int n_chk;
    int n_err;

    typedef struct {
        logic [31:0] w;
        logic [31:0] pc;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_pc;
    int          m_ph;
    bit          m_hold;

    instr_fetch_unit_if #(.ADDR_W(5), .DEPTH(DEPTH)) bus ();

    instr_fetch_unit #(
        .DEPTH(DEPTH),
        .ADDR_W(5),
        .RESET_PC(32'h0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    assign bus.imem_rdata = mem[bus.imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        logic [4:0] a;
        a = pc[4:0];
        return {mem[a], mem[a + 5'd1], mem[a + 5'd2], mem[a + 5'd3]};
    endfunction

    task automatic model_edge();
        bit pop;
        bit room;
        if (!rst_n) begin
            m_q.delete();
            m_pc   = 32'h0;
            m_ph   = 0;
            m_hold = 0;
        end else if (bus.redirect) begin
            m_q.delete();
            m_pc   = {bus.redirect_pc[31:2], 2'b00};
            m_ph   = 0;
            m_hold = 0;
        end else begin
            pop  = (m_q.size() != 0) && bus.inst_ready;
            room = (m_q.size() < DEPTH) || pop;
            if (pop) void'(m_q.pop_front());
            if (m_hold || m_ph == 3) begin
                if (room) begin
                    m_q.push_back('{w: word_at(m_pc), pc: m_pc});
                    m_pc   = m_pc + 32'd4;
                    m_ph   = 0;
                    m_hold = 0;
                end else begin
                    m_hold = 1;
                end
            end else begin
                m_ph++;
            end
        end
    endtask

    task automatic check_model();
        logic [31:0] a;
        a = m_pc + 32'(m_hold ? 3 : m_ph);
        check("valid", 64'(bus.inst_valid), 64'(m_q.size() != 0));
        check("count", 64'(bus.fifo_count), 64'(m_q.size()));
        check("stall", 64'(bus.fetch_stall), 64'(m_hold));
        check("addr", 64'(bus.imem_addr), 64'(a[4:0]));
        if (m_q.size() != 0) begin
            check("inst", 64'(bus.inst), 64'(m_q[0].w));
            check("inst_pc", 64'(bus.inst_pc), 64'(m_q[0].pc));
        end
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        int maxc;
        n_chk = 0;
        n_err = 0;
        for (int i = 0; i < 32; i++) mem[i] = 8'(i);
        rst_n           = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.inst_ready  = 1'b0;

        cyc();
        cyc();
        check("rst_inst", 64'(bus.inst), 64'h0);
        check("rst_inst_pc", 64'(bus.inst_pc), 64'h0);
        check("rst_addr", 64'(bus.imem_addr), 64'h0);

        // Streaming with ready held high
        rst_n = 1'b1;
        bus.inst_ready = 1'b1;
        repeat (4) cyc();
        check("t1_inst", 64'(bus.inst), 64'h00010203);
        check("t1_pc", 64'(bus.inst_pc), 64'h0);
        repeat (4) cyc();
        check("t1_inst2", 64'(bus.inst), 64'h04050607);
        check("t1_pc2", 64'(bus.inst_pc), 64'h4);
        maxc = 0;
        repeat (12) begin
            cyc();
            if (int'(bus.fifo_count) > maxc) maxc = int'(bus.fifo_count);
        end
        check("t1_maxcnt", 64'(maxc), 64'd1);

        // Fill FIFO, HOLD, single pop
        do_reset();
        bus.inst_ready = 1'b0;
        repeat (16) cyc();
        check("t2_cnt16", 64'(bus.fifo_count), 64'd4);
        repeat (4) cyc();
        check("t2_stall", 64'(bus.fetch_stall), 64'd1);
        check("t2_addr", 64'(bus.imem_addr), 64'h13);
        cyc();
        check("t2_addr_hold", 64'(bus.imem_addr), 64'h13);
        bus.inst_ready = 1'b1;
        cyc();
        bus.inst_ready = 1'b0;
        check("t2_head", 64'(bus.inst), 64'h04050607);
        check("t2_cnt", 64'(bus.fifo_count), 64'd4);
        check("t2_unstall", 64'(bus.fetch_stall), 64'd0);
        check("t2_addr14", 64'(bus.imem_addr), 64'h14);

        // Reset while in HOLD
        repeat (4) cyc();
        check("t3_stall", 64'(bus.fetch_stall), 64'd1);
        do_reset();
        check("t3_cnt", 64'(bus.fifo_count), 64'd0);
        check("t3_valid", 64'(bus.inst_valid), 64'd0);
        check("t3_stall0", 64'(bus.fetch_stall), 64'd0);
        check("t3_addr", 64'(bus.imem_addr), 64'h0);

        // Redirect mid-word to an unaligned PC
        repeat (2) cyc();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000000E;
        cyc();
        bus.redirect = 1'b0;
        check("t4_cnt", 64'(bus.fifo_count), 64'd0);
        check("t4_valid", 64'(bus.inst_valid), 64'd0);
        check("t4_addr", 64'(bus.imem_addr), 64'h0C);
        repeat (4) cyc();
        check("t4_inst", 64'(bus.inst), 64'h0C0D0E0F);
        check("t4_pc", 64'(bus.inst_pc), 64'h0C);

        // Redirect near the top of memory: address wrap
        bus.inst_ready  = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000001C;
        cyc();
        bus.redirect = 1'b0;
        repeat (3) cyc();
        check("t5_addr1f", 64'(bus.imem_addr), 64'h1F);
        cyc();
        check("t5_inst", 64'(bus.inst), 64'h1C1D1E1F);
        check("t5_pc", 64'(bus.inst_pc), 64'h1C);
        check("t5_addr00", 64'(bus.imem_addr), 64'h00);
        repeat (4) cyc();
        check("t5_inst2", 64'(bus.inst), 64'h00010203);
        check("t5_pc2", 64'(bus.inst_pc), 64'h20);

        // Redirect and pop on the same edge with three entries
        do_reset();
        bus.inst_ready = 1'b0;
        repeat (12) cyc();
        check("t6_cnt3", 64'(bus.fifo_count), 64'd3);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0;
        bus.inst_ready  = 1'b1;
        cyc();
        bus.redirect   = 1'b0;
        bus.inst_ready = 1'b0;
        check("t6_cnt", 64'(bus.fifo_count), 64'd0);
        check("t6_valid", 64'(bus.inst_valid), 64'd0);
        repeat (4) cyc();
        check("t6_cnt1", 64'(bus.fifo_count), 64'd1);
        check("t6_inst", 64'(bus.inst), 64'h00010203);

        // Randomized traffic on random memory contents
        rst_n = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
        cyc();
        rst_n = 1'b1;
        repeat (1500) begin
            bus.inst_ready  = ($urandom_range(9) < 7);
            bus.redirect    = ($urandom_range(31) == 0);
            bus.redirect_pc = $urandom;
            rst_n           = ($urandom_range(99) != 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
